// File: rtl/alu_issue_ctrl.sv
// Issue/response front-end for the 64-bit ALU; ALU_ISSUE_ILLEGAL_TRAP_EN forces a trap response for illegal ops.
// Latency: accept at edge t, response valid after edge t+1; one op in flight, min spacing 3 cycles.
// Backpressure: response held stable while resp_ready is low; req_ready low until the response is taken.
module alu_issue_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_alu_op,
    input  logic [10:0]           req_opcode,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    output logic [3:0]            alu_signal,
    output logic [DATA_WIDTH-1:0] alu_data_a,
    output logic [DATA_WIDTH-1:0] alu_data_b,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_result,
    output logic                  resp_zero,
    output logic                  resp_err,
    output logic [CNT_WIDTH-1:0]  op_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] SIG_AND     = 4'b0000;
    localparam logic [3:0] SIG_ORR     = 4'b0001;
    localparam logic [3:0] SIG_ADD     = 4'b0010;
    localparam logic [3:0] SIG_SUB     = 4'b0110;
    localparam logic [3:0] SIG_PASS_B  = 4'b0111;
    localparam logic [3:0] SIG_NOR     = 4'b1100;
    localparam logic [3:0] SIG_ILLEGAL = 4'b1111;

    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;
    localparam logic [10:0] OPC_NOR = 11'b11101010000;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0] state;
    logic [3:0] dec_signal;

    assign req_ready = (state == ST_IDLE);

    always_comb begin
        dec_signal = SIG_ILLEGAL;
        case (req_alu_op)
            2'b00: dec_signal = SIG_ADD;
            2'b01: dec_signal = SIG_PASS_B;
            2'b10: begin
                case (req_opcode)
                    OPC_ADD: dec_signal = SIG_ADD;
                    OPC_SUB: dec_signal = SIG_SUB;
                    OPC_AND: dec_signal = SIG_AND;
                    OPC_ORR: dec_signal = SIG_ORR;
                    OPC_NOR: dec_signal = SIG_NOR;
                    default: dec_signal = SIG_ILLEGAL;
                endcase
            end
            default: dec_signal = SIG_ILLEGAL;
        endcase
    end

`ifndef ALU_ISSUE_ILLEGAL_TRAP_EN
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            alu_signal  <= 4'b0000;
            alu_data_a  <= '0;
            alu_data_b  <= '0;
            resp_valid  <= 1'b0;
            resp_result <= '0;
            resp_zero   <= 1'b0;
            op_count    <= '0;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
            resp_err    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        alu_signal <= dec_signal;
                        alu_data_a <= req_a;
                        alu_data_b <= req_b;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
                    // 1111 is only ever issued for an illegal decode, so it doubles as the trap flag.
                    if (alu_signal == SIG_ILLEGAL) begin
                        resp_result <= '0;
                        resp_zero   <= 1'b1;
                        resp_err    <= 1'b1;
                    end else begin
                        resp_result <= alu_result;
                        resp_zero   <= alu_zero;
                        resp_err    <= 1'b0;
                    end
`else
                    resp_result <= alu_result;
                    resp_zero   <= alu_zero;
`endif
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        op_count   <= op_count + CNT_ONE;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural model of the 64-bit ALU on its control/operand outputs.
module tb_alu_issue_ctrl;

    localparam int DW = 64;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_alu_op;
    logic [10:0]   req_opcode;
    logic [DW-1:0] req_a, req_b;
    logic [3:0]    alu_signal;
    logic [DW-1:0] alu_data_a, alu_data_b;
    logic [DW-1:0] alu_result;
    logic          alu_zero;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_result;
    logic          resp_zero;
    logic          resp_err;
    logic [CW-1:0] op_count;

    int            n_checks = 0;
    int            n_fails  = 0;
    logic [CW-1:0] exp_cnt;
    logic          exp_err_illegal;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_alu_op(req_alu_op), .req_opcode(req_opcode),
        .req_a(req_a), .req_b(req_b),
        .alu_signal(alu_signal), .alu_data_a(alu_data_a), .alu_data_b(alu_data_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err),
        .op_count(op_count)
    );

    // Combinational ALU model: LEGv8 control codes, anything unknown yields 0.
    always_comb begin
        alu_result = '0;
        case (alu_signal)
            4'b0010: alu_result = alu_data_a + alu_data_b;
            4'b0110: alu_result = alu_data_a - alu_data_b;
            4'b0000: alu_result = alu_data_a & alu_data_b;
            4'b0001: alu_result = alu_data_a | alu_data_b;
            4'b1100: alu_result = ~(alu_data_a | alu_data_b);
            4'b0111: alu_result = alu_data_b;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic send_req(input logic [1:0] op, input logic [10:0] opc,
                            input logic [DW-1:0] a, input logic [DW-1:0] b);
        bit ok;
        ok = 1'b0;
        req_alu_op = op; req_opcode = opc; req_a = a; req_b = b;
        req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fails++;
            $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
        req_alu_op = 2'b00; req_opcode = '0; req_a = '0; req_b = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_cnt = '0;
        n_checks++; if (req_ready !== 1'b1) begin n_fails++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_zero !== 1'b0) begin n_fails++; $display("FAIL reset_resp_flags: valid=%b err=%b zero=%b want 0/0/0", resp_valid, resp_err, resp_zero); end
        n_checks++; if (resp_result !== '0 || op_count !== '0) begin n_fails++; $display("FAIL reset_result_cnt: result=%h cnt=%0d want 0/0", resp_result, op_count); end
        n_checks++; if (alu_signal !== 4'b0000 || alu_data_a !== '0 || alu_data_b !== '0) begin n_fails++; $display("FAIL reset_alu_inputs: sig=%b a=%h b=%h want 0", alu_signal, alu_data_a, alu_data_b); end

        // Drop an in-flight op with a two-cycle reset pulse starting in EXEC.
        send_req(2'b10, 11'b10001011000, 64'd5, 64'd7);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n_checks++; if (resp_valid !== 1'b0 || op_count !== '0) begin n_fails++; $display("FAIL midop_reset: valid=%b cnt=%0d want 0/0", resp_valid, op_count); end
        n_checks++; if (alu_signal !== 4'b0000 || alu_data_a !== '0 || alu_data_b !== '0) begin n_fails++; $display("FAIL midop_reset_alu: sig=%b a=%h b=%h want 0", alu_signal, alu_data_a, alu_data_b); end
        n_checks++; if (req_ready !== 1'b1) begin n_fails++; $display("FAIL midop_reset_ready: got %b want 1", req_ready); end
        @(posedge clk); #1;
        n_checks++; if (resp_valid !== 1'b0) begin n_fails++; $display("FAIL midop_reset_noresp: valid=%b want 0", resp_valid); end
    endtask

    task automatic test_add;
        resp_ready = 1'b1;
        send_req(2'b10, 11'b10001011000, 64'd5, 64'd7);
        n_checks++; if (alu_signal !== 4'b0010) begin n_fails++; $display("FAIL add_signal: got %b want 0010", alu_signal); end
        n_checks++; if (alu_data_a !== 64'd5 || alu_data_b !== 64'd7) begin n_fails++; $display("FAIL add_operands: a=%0d b=%0d want 5/7", alu_data_a, alu_data_b); end
        n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin n_fails++; $display("FAIL add_exec_state: valid=%b ready=%b want 0/0", resp_valid, req_ready); end
        @(posedge clk); #1;
        n_checks++; if (resp_valid !== 1'b1 || resp_result !== 64'd12 || resp_zero !== 1'b0) begin n_fails++; $display("FAIL add_resp: valid=%b result=%0d zero=%b want 1/12/0", resp_valid, resp_result, resp_zero); end
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 1'b1;
        n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || op_count !== exp_cnt) begin n_fails++; $display("FAIL add_done: valid=%b ready=%b cnt=%0d want 0/1/%0d", resp_valid, req_ready, op_count, exp_cnt); end
    endtask

    task automatic test_sub_zero;
        resp_ready = 1'b1;
        send_req(2'b10, 11'b11001011000, 64'h1234, 64'h1234);
        n_checks++; if (alu_signal !== 4'b0110) begin n_fails++; $display("FAIL sub_signal: got %b want 0110", alu_signal); end
        @(posedge clk); #1;
        n_checks++; if (resp_valid !== 1'b1 || resp_result !== '0 || resp_zero !== 1'b1) begin n_fails++; $display("FAIL sub_resp: valid=%b result=%h zero=%b want 1/0/1", resp_valid, resp_result, resp_zero); end
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 1'b1;
        n_checks++; if (op_count !== exp_cnt) begin n_fails++; $display("FAIL sub_count: got %0d want %0d", op_count, exp_cnt); end
    endtask

    task automatic test_decode;
        logic [1:0]    t_op  [5];
        logic [10:0]   t_opc [5];
        logic [DW-1:0] t_a   [5];
        logic [DW-1:0] t_b   [5];
        logic [3:0]    t_sig [5];
        logic [DW-1:0] t_res [5];
        t_op[0] = 2'b00; t_opc[0] = 11'b11001011000; t_a[0] = 64'd100;    t_b[0] = 64'd23;    t_sig[0] = 4'b0010; t_res[0] = 64'd123;
        t_op[1] = 2'b10; t_opc[1] = 11'b10001010000; t_a[1] = 64'hF0F0;   t_b[1] = 64'hFF00;  t_sig[1] = 4'b0000; t_res[1] = 64'hF000;
        t_op[2] = 2'b10; t_opc[2] = 11'b10101010000; t_a[2] = 64'hF0;     t_b[2] = 64'h0F;    t_sig[2] = 4'b0001; t_res[2] = 64'hFF;
        t_op[3] = 2'b10; t_opc[3] = 11'b11101010000; t_a[3] = 64'h0;      t_b[3] = 64'h0;     t_sig[3] = 4'b1100; t_res[3] = 64'hFFFF_FFFF_FFFF_FFFF;
        t_op[4] = 2'b01; t_opc[4] = 11'b10001011000; t_a[4] = 64'd9;      t_b[4] = 64'd42;    t_sig[4] = 4'b0111; t_res[4] = 64'd42;
        resp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_req(t_op[i], t_opc[i], t_a[i], t_b[i]);
            n_checks++; if (alu_signal !== t_sig[i]) begin n_fails++; $display("FAIL decode_signal[%0d]: got %b want %b", i, alu_signal, t_sig[i]); end
            @(posedge clk); #1;
            n_checks++; if (resp_valid !== 1'b1 || resp_result !== t_res[i]) begin n_fails++; $display("FAIL decode_result[%0d]: valid=%b result=%h want 1/%h", i, resp_valid, resp_result, t_res[i]); end
            @(posedge clk); #1;
            exp_cnt = exp_cnt + 1'b1;
            n_checks++; if (op_count !== exp_cnt) begin n_fails++; $display("FAIL decode_count[%0d]: got %0d want %0d", i, op_count, exp_cnt); end
        end
    endtask

    task automatic test_backpressure;
        resp_ready = 1'b0;
        send_req(2'b01, 11'b0, 64'h55, 64'hFFFF_FFFF_FFFF_FFFF);
        n_checks++; if (alu_signal !== 4'b0111) begin n_fails++; $display("FAIL bp_signal: got %b want 0111", alu_signal); end
        @(posedge clk); #1;
        n_checks++; if (resp_valid !== 1'b1 || resp_result !== 64'hFFFF_FFFF_FFFF_FFFF || resp_zero !== 1'b0) begin n_fails++; $display("FAIL bp_resp: valid=%b result=%h zero=%b want 1/all-ones/0", resp_valid, resp_result, resp_zero); end
        // A competing request held during RESP must not disturb the issued operands.
        req_alu_op = 2'b10; req_opcode = 11'b10001011000; req_a = 64'hDEAD; req_b = 64'hBEEF; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (resp_valid !== 1'b1 || resp_result !== 64'hFFFF_FFFF_FFFF_FFFF || resp_zero !== 1'b0 || req_ready !== 1'b0 || op_count !== exp_cnt) begin
                n_fails++;
                $display("FAIL bp_hold[%0d]: valid=%b result=%h zero=%b ready=%b cnt=%0d want 1/all-ones/0/0/%0d", i, resp_valid, resp_result, resp_zero, req_ready, op_count, exp_cnt);
            end
            n_checks++; if (alu_signal !== 4'b0111 || alu_data_a !== 64'h55) begin n_fails++; $display("FAIL bp_alu_stable[%0d]: sig=%b a=%h want 0111/55", i, alu_signal, alu_data_a); end
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 1'b1;
        n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || op_count !== exp_cnt) begin n_fails++; $display("FAIL bp_release: valid=%b ready=%b cnt=%0d want 0/1/%0d", resp_valid, req_ready, op_count, exp_cnt); end
    endtask

    task automatic test_illegal;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        exp_err_illegal = 1'b1;
`else
        exp_err_illegal = 1'b0;
`endif
        resp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) send_req(2'b11, 11'b10001011000, 64'd9, 64'd3);
            else        send_req(2'b10, 11'b11111111111, 64'd9, 64'd3);
            n_checks++; if (alu_signal !== 4'b1111) begin n_fails++; $display("FAIL illegal_signal[%0d]: got %b want 1111", i, alu_signal); end
            @(posedge clk); #1;
            n_checks++;
            if (resp_valid !== 1'b1 || resp_result !== '0 || resp_zero !== 1'b1 || resp_err !== exp_err_illegal) begin
                n_fails++;
                $display("FAIL illegal_resp[%0d]: valid=%b result=%h zero=%b err=%b want 1/0/1/%b", i, resp_valid, resp_result, resp_zero, resp_err, exp_err_illegal);
            end
            @(posedge clk); #1;
            exp_cnt = exp_cnt + 1'b1;
            n_checks++; if (op_count !== exp_cnt) begin n_fails++; $display("FAIL illegal_count[%0d]: got %0d want %0d", i, op_count, exp_cnt); end
        end
        // A legal op afterwards must report no error.
        send_req(2'b00, 11'b0, 64'd1, 64'd1);
        @(posedge clk); #1;
        n_checks++; if (resp_err !== 1'b0 || resp_result !== 64'd2) begin n_fails++; $display("FAIL illegal_recover: err=%b result=%0d want 0/2", resp_err, resp_result); end
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic test_wrap;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        resp_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            send_req(2'b10, 11'b10001011000, 64'(i), 64'd1);
            @(posedge clk); #1;
            @(posedge clk); #1;
            if (i == 15) begin
                n_checks++; if (op_count !== 4'd0) begin n_fails++; $display("FAIL wrap_16: got %0d want 0", op_count); end
            end
        end
        n_checks++; if (op_count !== 4'd1) begin n_fails++; $display("FAIL wrap_17: got %0d want 1", op_count); end
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub_zero;
        test_decode;
        test_backpressure;
        test_illegal;
        test_wrap;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential front-end that drives the 64-bit combinational ALU. It accepts LEGv8-style operation requests over a valid/ready handshake and decodes ALUOp/opcode into the 4-bit ALU control code. It presents registered operands to the ALU, captures the ALU result and zero flag, and returns them on a valid/ready response channel. It sits between the datapath sequencer and the ALU, owning the ALU's control and operand inputs.

## Interface
- DATA_WIDTH, 64, operand/result width
- CNT_WIDTH, 16, width of completed-operation counter
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept request
- req_alu_op  in  2  ALUOp class (00 load/store add, 01 branch pass-B, 10 R-type)
- req_opcode  in  11  instruction opcode field, used when req_alu_op=10
- req_a, req_b  in  DATA_WIDTH  operands
- alu_signal  out  4  ALU control code
- alu_data_a, alu_data_b  out  DATA_WIDTH  ALU operands
- alu_result  in  DATA_WIDTH  ALU combinational result
- alu_zero  in  1  ALU zero flag
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_result  out  DATA_WIDTH  captured result
- resp_zero  out  1  captured zero flag
- resp_err  out  1  illegal-operation indication
- op_count  out  CNT_WIDTH  completed responses, wraps

## Operation
- States: IDLE, EXEC, RESP. Reset state IDLE.
- req_ready = (state==IDLE), combinational from state.
- IDLE: on req_valid&&req_ready, register decoded alu_signal, req_a→alu_data_a, req_b→alu_data_b, go EXEC.
- Decode: alu_op 00→0010 (add); 01→0111 (pass B); 10 with opcode 10001011000→0010 ADD, 11001011000→0110 SUB, 10001010000→0000 AND, 10101010000→0001 ORR, 11101010000→1100 NOR-form; anything else (incl. alu_op 11) is illegal.
- EXEC: sample alu_result→resp_result, alu_zero→resp_zero, set resp_valid, go RESP.
- RESP: hold resp_* stable while resp_valid&&!resp_ready. On resp_ready: clear resp_valid, op_count+1 (wraps 2^CNT_WIDTH−1→0), go IDLE.
- alu_signal/alu_data_* hold last issued values until next accept; never change in EXEC or RESP.
- No arithmetic performed locally; widths pass through unchanged.

## Timing
- Reset (rst_n low at a rising edge): state IDLE, resp_valid 0, resp_result 0, resp_zero 0, resp_err 0, alu_signal 0000, alu_data_a/b 0, op_count 0. req_ready reads 1 the cycle after reset.
- Accept at edge t → ALU inputs valid cycle t..t+1 → resp_valid high after edge t+1 (2-cycle latency).
- Min request spacing 3 cycles (accept, EXEC, RESP with resp_ready high).
- resp_ready high in RESP: response completes that edge; req_ready rises next cycle (no same-cycle turnaround).
- Reset mid-operation (EXEC or RESP): in-flight op dropped, no response, op_count not incremented.
- req_valid in EXEC/RESP ignored; requester must hold it until req_ready.

## Configuration
- ALU_ISSUE_ILLEGAL_TRAP_EN defined: illegal decode still takes IDLE→EXEC→RESP, but alu_signal is driven 1111 and resp_err=1, resp_result=0, resp_zero=1 regardless of ALU inputs; op_count increments normally.
- Undefined: illegal decode issues 1111 (ALU default path yields 0), resp_result/resp_zero taken from ALU as usual; resp_err tied 0.

## Test plan
- Reset: assert rst_n=0 for 2 cycles mid-EXEC → all outputs at reset values, no resp_valid, op_count=0.
- ADD: alu_op=10, opcode=10001011000, a=5, b=7 → alu_signal=0010 in cycle after accept; resp_valid 2 cycles after accept with result=12, zero=0, op_count=1.
- SUB zero: alu_op=10, opcode=11001011000, a=b=0x1234 → alu_signal=0110, resp_result=0, resp_zero=1.
- Backpressure: pass-B (alu_op=01, b=0xFFFF_FFFF_FFFF_FFFF) with resp_ready low 5 cycles → resp_* stable, req_ready 0; response completes on first resp_ready edge, req_ready 1 next cycle.
- Illegal: alu_op=11 → with ALU_ISSUE_ILLEGAL_TRAP_EN resp_err=1, result=0, zero=1; without it resp_err=0, result=0 from ALU.
- Wrap: CNT_WIDTH=4, complete 17 ops → op_count=1.
